// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Shares one memory bus between the fetch and data ports: data-first
// arbitration, fetch starvation guard, per-access timeout with sticky error.
// Rev    : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255,
    parameter int TW           = 8
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [15:0] i_data,
    output logic        i_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_32bit,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_32bit,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        bus_err
);

    localparam int            c_streak_w     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_streak_w-1:0] c_starve_limit = c_streak_w'(STARVE_LIMIT);
    localparam logic [TW-1:0] c_timeout      = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_D = 2'd1,
        ST_BUSY_I = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_streak_w-1:0]   r_streak;
    logic [TW-1:0]           r_tcnt;

    logic w_d_pend;
    logic w_i_pend;
    logic w_force_i;
    logic w_grant_d;
    logic w_grant_i;
    logic w_tout;

    // A request seen during its own valid cycle belongs to the finished access.
    assign w_d_pend  = d_req & ~d_valid;
    assign w_i_pend  = i_req & ~i_valid;
    assign stall     = w_d_pend | w_i_pend;

    assign w_force_i = (STARVE_LIMIT != 0) && w_i_pend && (r_streak == c_starve_limit);
    assign w_grant_d = w_d_pend && !w_force_i;
    assign w_grant_i = w_i_pend && !w_grant_d;
    assign w_tout    = (TIMEOUT != 0) && ((r_tcnt + TW'(1)) == c_timeout);

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_streak  <= '0;
            r_tcnt    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_32bit <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            i_valid   <= 1'b0;
            i_data    <= 16'h0;
            d_valid   <= 1'b0;
            d_rdata   <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= ST_BUSY_D;
                        r_tcnt    <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_32bit <= d_32bit;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (!w_i_pend) begin
                            r_streak <= '0;
                        end else if (r_streak != c_starve_limit) begin
                            r_streak <= r_streak + c_streak_w'(1);
                        end
                    end else if (w_grant_i) begin
                        r_state   <= ST_BUSY_I;
                        r_tcnt    <= '0;
                        r_streak  <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_32bit <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= 32'h0;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ack) begin
                        r_state <= ST_IDLE;
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_32bit ? mem_rdata : {16'h0, mem_rdata[15:0]};
                        end
                    end else if (w_tout) begin
                        r_state <= ST_IDLE;
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        d_rdata <= 32'h0;
                        bus_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                ST_BUSY_I: begin
                    if (mem_ack) begin
                        r_state <= ST_IDLE;
                        mem_req <= 1'b0;
                        i_valid <= 1'b1;
                        i_data  <= mem_rdata[15:0];
                    end else if (w_tout) begin
                        r_state <= ST_IDLE;
                        mem_req <= 1'b0;
                        i_valid <= 1'b1;
                        i_data  <= 16'h0;
                        bus_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
